cmp_minmax_scanner: RTL

Sequential controller that shares one 4-bit magnitude comparator to find the maximum and minimum of a burst of N unsigned 4-bit samples. Samples arrive over a valid/ready handshake. For each sample the block schedules two comparisons on the single comparator, first against the running max and then against the running min. It reports values and first-occurrence indices with a one-cycle DONE pulse. It sits between a sample source (switches, shift register or FIFO) and display logic.

---
 rtl/cmp_pkg.sv | 25 ++
 rtl/digital_comparator_5.sv | 21 ++
 rtl/cmp_minmax_scanner.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared constants for the min/max scanner: comparator result coding and
// the controller state encoding.
package cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FIRST   = 3'd1;
  localparam logic [2:0] ST_ACCEPT  = 3'd2;
  localparam logic [2:0] ST_CMP_MAX = 3'd3;
  localparam logic [2:0] ST_CMP_MIN = 3'd4;
  localparam logic [2:0] ST_FIN     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_FIRST   = ST_FIRST,
    S_ACCEPT  = ST_ACCEPT,
    S_CMP_MAX = ST_CMP_MAX,
    S_CMP_MIN = ST_CMP_MIN,
    S_FIN     = ST_FIN
  } state_e;

endpackage

// File: rtl/digital_comparator_5.sv
// 4-bit unsigned magnitude comparator with one-hot result:
// 100 = A>B, 010 = A=B, 001 = A<B.
module digital_comparator_5
  import cmp_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [2:0] Y
);

  always_comb begin
    if (A > B) begin
      Y = CMP_GT;
    end else if (A == B) begin
      Y = CMP_EQ;
    end else begin
      Y = CMP_LT;
    end
  end

endmodule

// File: rtl/cmp_minmax_scanner.sv
// Burst min/max finder: one shared comparator is time-multiplexed between the
// running max and running min, giving one sample every three cycles.
module cmp_minmax_scanner
  import cmp_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [3:0]    IN_DATA,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic [3:0]    MAX,
  output logic [3:0]    MIN,
  output logic [IW-1:0] MAX_IDX,
  output logic [IW-1:0] MIN_IDX,
  output logic          BUSY,
  output logic          DONE
);

  // One bit wider than the count so the final increment to N is representable.
  localparam logic [IW:0] N_LAST = (IW+1)'(N);

  state_e        state_q,   state_d;
  logic [IW-1:0] count_q,   count_d;
  logic [IW-1:0] sidx_q,    sidx_d;
  logic [3:0]    sample_q,  sample_d;
  logic [3:0]    max_q,     max_d;
  logic [3:0]    min_q,     min_d;
  logic [IW-1:0] max_idx_q, max_idx_d;
  logic [IW-1:0] min_idx_q, min_idx_d;

  logic [3:0]    cmp_b;
  logic [2:0]    cmp_y;
  logic [IW:0]   count_inc;

  // A is always the held sample; B selects the running extreme under test.
  assign cmp_b = (state_q == S_CMP_MIN) ? min_q : max_q;

  digital_comparator_5 u_cmp (
    .A (sample_q),
    .B (cmp_b),
    .Y (cmp_y)
  );

  assign count_inc = {1'b0, count_q} + (IW+1)'(1);

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    sidx_d    = sidx_q;
    sample_d  = sample_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_FIRST;
          count_d = '0;
        end
      end
      S_FIRST: begin
        if (IN_VALID) begin
          max_d     = IN_DATA;
          min_d     = IN_DATA;
          max_idx_d = '0;
          min_idx_d = '0;
          count_d   = IW'(1);
          state_d   = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (IN_VALID) begin
          sample_d = IN_DATA;
          sidx_d   = count_q;
          state_d  = S_CMP_MAX;
        end
      end
      S_CMP_MAX: begin
        // Strict compare: equal values keep the earlier index.
        if (cmp_y == CMP_GT) begin
          max_d     = sample_q;
          max_idx_d = sidx_q;
        end
        state_d = S_CMP_MIN;
      end
      S_CMP_MIN: begin
        if (cmp_y == CMP_LT) begin
          min_d     = sample_q;
          min_idx_d = sidx_q;
        end
        count_d = count_inc[IW-1:0];
        state_d = (count_inc == N_LAST) ? S_FIN : S_ACCEPT;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      sidx_q    <= '0;
      sample_q  <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else begin
      // NOTE: non-blocking so all flops sample the pre-edge values together.
      state_q   <= state_d;
      count_q   <= count_d;
      sidx_q    <= sidx_d;
      sample_q  <= sample_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
    end
  end

  // Handshake and status decode only from registered state; IN_VALID never
  // reaches IN_READY combinationally.
  assign IN_READY = (state_q == S_FIRST) || (state_q == S_ACCEPT);
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_FIN);
  assign MAX      = max_q;
  assign MIN      = min_q;
  assign MAX_IDX  = max_idx_q;
  assign MIN_IDX  = min_idx_q;

endmodule
